// File: rtl/mac_seq_ctrl_if.sv
// Handshake, result and shared-adder bus of the MAC sequencing controller.
// slave = controller view, master = environment (operand source, adder, result sink).
interface mac_seq_ctrl_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             clr_acc;
  logic [ACC_W-1:0] add_A;
  logic [ACC_W-1:0] add_B;
  logic             add_Cin;
  logic [ACC_W-1:0] add_Sum;
  logic             add_Cout;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             overflow;

  modport slave (
    input  in_valid, op_a, op_b, clr_acc, add_Sum, add_Cout,
    output in_ready, add_A, add_B, add_Cin, acc_out, out_valid, overflow
  );

  modport master (
    output in_valid, op_a, op_b, clr_acc, add_Sum, add_Cout,
    input  in_ready, add_A, add_B, add_Cin, acc_out, out_valid, overflow
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Multiply-accumulate sequencer time-sharing one external ripple-carry adder.
// Optional macro MAC_SEQ_EARLY_EXIT_EN: leave MUL once the remaining multiplier bits are zero.
module mac_seq_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (ACC_W < 2 * WIDTH) begin : g_cfg_err
    $error("mac_seq_ctrl: ACC_W must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_p;
  logic [ACC_W-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic               r_out_valid;
  logic               r_in_ready;

  logic               w_accept;
  logic [WIDTH-1:0]   w_q_shr;
  logic               w_mul_last;
  logic [ACC_W-1:0]   w_add_a;
  logic [ACC_W-1:0]   w_add_b;

  // r_in_ready is only ever set while in IDLE, so it also qualifies the state.
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_q_shr  = r_q >> 1;

`ifdef MAC_SEQ_EARLY_EXIT_EN
  assign w_mul_last = (w_q_shr == '0) || (r_cnt == CNT_W'(WIDTH - 1));
`else
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_p         <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_p        <= '0;
            r_m        <= ACC_W'(bus.op_a);
            r_q        <= bus.op_b;
            r_cnt      <= '0;
            r_state    <= S_MUL;
            r_in_ready <= 1'b0;
            if (bus.clr_acc) begin
              r_acc <= '0;
              r_ovf <= 1'b0;
            end
          end
        end
        S_MUL: begin
          r_p   <= bus.add_Sum;
          r_m   <= r_m << 1;
          r_q   <= w_q_shr;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_mul_last) begin
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc       <= bus.add_Sum;
          r_ovf       <= r_ovf | bus.add_Cout;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_in_ready <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Adder operands depend only on registered state; the product never carries out.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      S_MUL: begin
        w_add_a = r_p;
        w_add_b = r_q[0] ? r_m : '0;
      end
      S_ACC: begin
        w_add_a = r_acc;
        w_add_b = r_p;
      end
      default: begin
        w_add_a = '0;
        w_add_b = '0;
      end
    endcase
  end

  assign bus.add_A     = w_add_a;
  assign bus.add_B     = w_add_b;
  assign bus.add_Cin   = 1'b0;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.acc_out   = r_acc;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural adder, accumulate model with result scoreboard,
// vector table plus hand-written reset / busy / latency sequences.
module tb_mac_seq_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned ACC_W = 32;

  logic clk;
  logic rst;

  mac_seq_ctrl_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  mac_seq_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ripple-carry adder.
  always_comb begin
    {bus.add_Cout, bus.add_Sum} = {1'b0, bus.add_A} + {1'b0, bus.add_B} + 33'(bus.add_Cin);
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] acc;
    logic        ovf;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_acc = '0;
  logic        m_ovf = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        clr;
    logic [31:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b);
`ifdef MAC_SEQ_EARLY_EXIT_EN
    int k = 1;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return k + 2;
`else
    return WIDTH + 2;
`endif
  endfunction

  // Scoreboard: every out_valid cycle must match the oldest pending result.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_acc", 64'(bus.acc_out), 64'(e.acc));
        check("sb_ovf", 64'(bus.overflow), 64'(e.ovf));
      end
    end
  end

  // Offer an operand pair, wait for the accepting edge, update model, push result.
  task automatic do_accept(input logic [15:0] a, input logic [15:0] b, input logic c);
    int w;
    logic [32:0] t;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.clr_acc  = c;
    w = 0;
    while (!bus.in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (w >= 60) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", w);
    end
    @(posedge clk);
    if (c) begin
      m_acc = '0;
      m_ovf = 1'b0;
    end
    t = 33'(m_acc) + 33'(a) * 33'(b);
    m_acc = t[31:0];
    m_ovf = m_ovf | t[32];
    sb_q.push_back('{acc: m_acc, ovf: m_ovf});
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges (accepting edge = 1) until out_valid; in_ready must stay low meanwhile.
  task automatic wait_done(input int exp_edges, input string tag);
    int n;
    bit rdy_seen;
    bit got;
    n = 1;
    rdy_seen = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.in_ready) rdy_seen = 1'b1;
      if (bus.out_valid) got = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_edges));
    check({tag, "_busy_ready"}, 64'(rdy_seen), 64'd0);
  endtask

  vec_t vecs[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd3,      16'd5,      1'b1, 32'd15,         1'b0};
    vecs[1] = '{16'd1000,   16'd2000,   1'b0, 32'd2000015,    1'b0};
    vecs[2] = '{16'hFFFF,   16'hFFFF,   1'b1, 32'hFFFE_0001,  1'b0};
    vecs[3] = '{16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFC_0002,  1'b1};
    vecs[4] = '{16'd1,      16'd1,      1'b1, 32'd1,          1'b0};
    vecs[5] = '{16'h8000,   16'h8000,   1'b1, 32'h4000_0000,  1'b0};
    vecs[6] = '{16'hFFFF,   16'd1,      1'b0, 32'h4000_FFFF,  1'b0};
    vecs[7] = '{16'd0,      16'h1234,   1'b0, 32'h4000_FFFF,  1'b0};
    vecs[8] = '{16'd2,      16'h8000,   1'b0, 32'h4001_FFFF,  1'b0};
    vecs[9] = '{16'h1234,   16'd0,      1'b0, 32'h4001_FFFF,  1'b0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.clr_acc  = 1'b0;
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_acc",       64'(bus.acc_out),   64'd0);
    check("rst_ovf",       64'(bus.overflow),  64'd0);
    check("rst_add_a",     64'(bus.add_A),     64'd0);
    check("rst_add_b",     64'(bus.add_B),     64'd0);
    check("rst_add_cin",   64'(bus.add_Cin),   64'd0);
    #21;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_accept(vecs[i].a, vecs[i].b, vecs[i].clr);
      wait_done(exp_lat(vecs[i].b), $sformatf("v%0d", i));
      check($sformatf("v%0d_acc", i), 64'(bus.acc_out),  64'(vecs[i].exp_acc));
      check($sformatf("v%0d_ovf", i), 64'(bus.overflow), 64'(vecs[i].exp_ovf));
    end

    // Busy: a pair held during an operation must wait for the next IDLE.
    do_accept(16'd2, 16'd3, 1'b1);
    bus.in_valid = 1'b1;
    bus.op_a     = 16'd7;
    bus.op_b     = 16'd7;
    bus.clr_acc  = 1'b0;
    wait_done(exp_lat(16'd3), "busy_first");
    check("busy_first_acc", 64'(bus.acc_out), 64'd6);
    do_accept(16'd7, 16'd7, 1'b0);
    wait_done(exp_lat(16'd7), "busy_second");
    check("busy_second_acc", 64'(bus.acc_out), 64'd55);

    // Reset on the 5th edge of an operation, asserted between clock edges.
    do_accept(16'h1234, 16'h5678, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_acc",       64'(bus.acc_out),   64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready",  64'(bus.in_ready),  64'd0);
    check("midrst_add_a",     64'(bus.add_A),     64'd0);
    check("midrst_add_b",     64'(bus.add_B),     64'd0);
    sb_q.delete();
    m_acc = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_rel_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_rel_acc",      64'(bus.acc_out),  64'd0);
    repeat (25) @(posedge clk);
    #1;
    check("midrst_no_result", 64'(bus.out_valid), 64'd0);

    // Minimal multiplier: shortest operation in the early-exit build.
    do_accept(16'd9, 16'd1, 1'b1);
    wait_done(exp_lat(16'd1), "b1");
    check("b1_acc", 64'(bus.acc_out), 64'd9);

    repeat (5) @(posedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencing controller for the MAC datapath.
- Performs unsigned multiply-accumulate, acc += op_a * op_b, by time-sharing one external ACC_W-bit ripple-carry adder (rca: A, B, Cin -> Sum, Cout).
- Shift-add multiply over WIDTH adder passes, then one accumulate pass.
- Valid/ready input handshake; one-cycle result pulse; sticky accumulator overflow flag.

Parameters:
- WIDTH, 16, operand width of op_a/op_b.
- ACC_W, 32, accumulator and adder width; must be >= 2*WIDTH (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  controller can accept; high only in IDLE.
- op_a  input  WIDTH  multiplicand, unsigned.
- op_b  input  WIDTH  multiplier, unsigned.
- clr_acc  input  1  sampled with accepted in_valid: start new accumulation (acc and overflow treated as 0).
- add_A  output  ACC_W  to adder A.
- add_B  output  ACC_W  to adder B.
- add_Cin  output  1  to adder Cin; always 0.
- add_Sum  input  ACC_W  from adder Sum (combinational, same cycle).
- add_Cout  input  1  from adder Cout.
- acc_out  output  ACC_W  accumulator register, always visible.
- out_valid  output  1  one-cycle pulse: acc_out holds the new result.
- overflow  output  1  sticky; set on any accumulate carry-out.

Behaviour:
- Reset (async, any state): state=IDLE; acc_out=0, overflow=0, out_valid=0, in_ready=1 once rst falls; internal P, M, Q, counter = 0; add_A/add_B/add_Cin=0. Reset mid-operation aborts with no out_valid.
- States: IDLE, MUL, ACC, DONE.
- IDLE:
  - in_ready=1; adder inputs 0.
  - Acceptance on a clock edge with in_valid=1: P<=0, M<=zero-extended op_a, Q<=op_b, cnt<=0, state<=MUL.
  - If clr_acc=1, acc<=0 and overflow<=0 on the same edge.
- MUL:
  - add_A=P; add_B = Q[0] ? M : 0.
  - Each edge: P<=add_Sum, M<=M<<1, Q<=Q>>1, cnt<=cnt+1.
  - Exit to ACC after WIDTH edges.
  - add_Cout ignored: the product cannot overflow ACC_W.
- ACC:
  - add_A=acc, add_B=P.
  - Edge: acc<=add_Sum, overflow<=overflow|add_Cout, state<=DONE.
- DONE:
  - out_valid=1 for exactly this cycle; in_ready=0.
  - Next edge -> IDLE.
- Latency: out_valid is high in the cycle following the (WIDTH+2)th edge after the accepting edge. Throughput: one op per WIDTH+3 cycles.
- in_valid while in_ready=0: ignored, no buffering; the operands and clr_acc of the operation in flight are unaffected.
- Accumulator wraps modulo 2^ACC_W on overflow; overflow stays set until an accepted clr_acc=1 or reset.
- in_ready, out_valid and adder drives are decoded from registered state only (no input-to-output combinational path except add_Sum -> register D inputs).

Optional Feature:
- Macro MAC_SEQ_EARLY_EXIT_EN.
- Defined: MUL exits to ACC after any MUL edge where the shifted Q becomes 0, or when cnt reaches WIDTH. At least one MUL cycle always occurs. Latency = k+2 edges, where k = max(1, bit index of op_b's MSB set + 1).
- Undefined: fixed WIDTH MUL cycles for every operand, as above.
- Results are identical in both builds.

Test Plan (WIDTH=16, ACC_W=32):
- Reset: assert rst mid-cycle with no clock -> all outputs 0 immediately; after release, in_ready=1, out_valid=0.
- op_a=3, op_b=5, clr_acc=1 -> out_valid pulse 18 edges after accept, acc_out=15, overflow=0, in_ready low during MUL/ACC/DONE.
- Back-to-back: then op_a=1000, op_b=2000, clr_acc=0 -> acc_out=2000015, overflow=0.
- Overflow: clr_acc=1, 65535*65535 -> acc_out=0xFFFE0001. Again with clr_acc=0 -> acc_out=0xFFFC0002, overflow=1. Next op 1*1 with clr_acc=1 -> acc_out=1, overflow=0.
- Busy stimulus: hold in_valid=1 with op_a=7, op_b=7 during an op of 2*3 (clr_acc=1) -> first result 6. The held pair is accepted only at the next IDLE, giving 55.
- Reset mid-MUL (edge 5) -> acc_out=0, no out_valid. With MAC_SEQ_EARLY_EXIT_EN defined, op_a=9, op_b=1 -> acc_out=9, out_valid after 3 edges.
